// File: rtl/cntr_pkg.sv
// Shared definitions for the counter family: default width and underflow mode.
package cntr_pkg;

  localparam int CNTR_DEFAULT_WIDTH = 3;

  // Behaviour of a counter when an enabled edge finds it at zero.
  typedef enum logic {
    MODE_WRAP   = 1'b0,  // wrap to all-ones
    MODE_RELOAD = 1'b1   // reload from the stored load value
  } underflow_mode_e;

endpackage

// File: rtl/sync_down_cntr.sv
// Synchronous loadable down counter with registered terminal-count pulse
// and optional auto-reload, usable as a divide-by-(N+1) pulse generator.
// All state shares one clock edge, so the count bits never skew.
module sync_down_cntr
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] fQ,
  output logic             zero,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             tc_r;

  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] reload_s;
  logic             tc_s;
  logic             at_zero_s;
  underflow_mode_e  mode_s;

  assign at_zero_s = (count_r == {WIDTH{1'b0}});
  assign mode_s    = underflow_mode_e'(auto_reload);

  // Next-state priority mux: load over count-enable over hold; reset is applied in the register.
  always_comb begin
    count_s  = count_r;
    reload_s = reload_r;
    tc_s     = 1'b0;
    if (load) begin
      count_s  = load_val;
      reload_s = load_val;
    end else if (en) begin
      if (at_zero_s) begin
        // Underflow: the mode is looked at only here.
        tc_s = 1'b1;
        case (mode_s)
          MODE_RELOAD: count_s = reload_r;
          MODE_WRAP:   count_s = {WIDTH{1'b1}};
          default:     count_s = {WIDTH{1'b1}};
        endcase
      end else begin
        count_s = count_r - WIDTH'(1'b1);
      end
    end else begin
      count_s = count_r;
    end
  end

  // State registers with synchronous active-high reset taking top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= {WIDTH{1'b0}};
      reload_r <= {WIDTH{1'b0}};
      tc_r     <= 1'b0;
    end else begin
      count_r  <= count_s;
      reload_r <= reload_s;
      tc_r     <= tc_s;
    end
  end

  assign fQ   = count_r;
  assign tc   = tc_r;
  // Decoded straight from the count register, so no input reaches it combinationally.
  assign zero = at_zero_s;

endmodule

// File: tb/tb_sync_down_cntr.sv
// Directed self-checking bench for sync_down_cntr at WIDTH = 3.
module tb_sync_down_cntr;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [2:0] load_val;
  logic       auto_reload;
  logic [2:0] fQ;
  logic       zero;
  logic       tc;

  int tests;
  int errors;

  sync_down_cntr #(.WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .fQ         (fQ),
    .zero       (zero),
    .tc         (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 3'd5; auto_reload = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (fQ !== 3'd0 || zero !== 1'b1 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: fQ=%0d zero=%b tc=%b, expected fQ=0 zero=1 tc=0", i, fQ, zero, tc);
      end
    end
    reset = 1'b0; load = 1'b0;
    step();
    tests++;
    if (fQ !== 3'd7 || tc !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: fQ=%0d tc=%b zero=%b, expected fQ=7 tc=1 zero=0", fQ, tc, zero);
    end
    step();
    tests++;
    if (fQ !== 3'd6 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_next: fQ=%0d tc=%b, expected fQ=6 tc=0", fQ, tc);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp;
    int pulses;
    reset = 1'b1; en = 1'b0; load = 1'b0; auto_reload = 1'b0;
    step();
    reset = 1'b0; en = 1'b1;
    exp = 3'd0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      exp = exp - 3'd1;
      step();
      if (tc === 1'b1) pulses++;
      tests++;
      if (fQ !== exp || tc !== (exp == 3'd7) || zero !== (exp == 3'd0)) begin
        errors++;
        $display("FAIL wrap[%0d]: fQ=%0d tc=%b zero=%b, expected fQ=%0d tc=%b zero=%b",
                 i, fQ, tc, zero, exp, (exp == 3'd7), (exp == 3'd0));
      end
    end
    tests++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d tc pulses, expected 2", pulses);
    end
    en = 1'b0;
  endtask

  task automatic test_divider();
    logic [2:0] exp;
    logic exp_tc;
    load_val = 3'd4; load = 1'b1; en = 1'b0;
    step();
    tests++;
    if (fQ !== 3'd4 || tc !== 1'b0) begin
      errors++;
      $display("FAIL div_load: fQ=%0d tc=%b, expected fQ=4 tc=0", fQ, tc);
    end
    load = 1'b0; auto_reload = 1'b1; en = 1'b1;
    exp = 3'd4;
    for (int i = 0; i < 10; i++) begin
      exp_tc = (exp == 3'd0);
      exp = exp_tc ? 3'd4 : exp - 3'd1;
      step();
      tests++;
      if (fQ !== exp || tc !== exp_tc) begin
        errors++;
        $display("FAIL divider[%0d]: fQ=%0d tc=%b, expected fQ=%0d tc=%b", i, fQ, tc, exp, exp_tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_simultaneous();
    load_val = 3'd0; load = 1'b1; en = 1'b0;
    step();
    tests++;
    if (fQ !== 3'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sim_setup: fQ=%0d zero=%b, expected fQ=0 zero=1", fQ, zero);
    end
    load_val = 3'd2; load = 1'b1; en = 1'b1;
    step();
    tests++;
    if (fQ !== 3'd2 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_over_en: fQ=%0d tc=%b, expected fQ=2 tc=0", fQ, tc);
    end
    reset = 1'b1; load = 1'b1; load_val = 3'd6; en = 1'b1;
    step();
    tests++;
    if (fQ !== 3'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_load: fQ=%0d tc=%b, expected fQ=0 tc=0", fQ, tc);
    end
    reset = 1'b0; load = 1'b0; auto_reload = 1'b1; en = 1'b1;
    step();
    tests++;
    if (fQ !== 3'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL reload_cleared: fQ=%0d tc=%b, expected fQ=0 tc=1", fQ, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic [3:0] en_seq;
    logic [2:0] exp;
    load_val = 3'd5; load = 1'b1; en = 1'b0; auto_reload = 1'b0;
    step();
    load = 1'b0;
    tests++;
    if (fQ !== 3'd5) begin
      errors++;
      $display("FAIL gate_load: fQ=%0d, expected 5", fQ);
    end
    en_seq = 4'b1001;
    exp = 3'd5;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[3-i];
      if (en_seq[3-i]) exp = exp - 3'd1;
      step();
      tests++;
      if (fQ !== exp || tc !== 1'b0) begin
        errors++;
        $display("FAIL gate[%0d]: fQ=%0d tc=%b, expected fQ=%0d tc=0", i, fQ, tc, exp);
      end
    end
    reset = 1'b1; en = 1'b1;
    step();
    reset = 1'b0; en = 1'b0;
    tests++;
    if (fQ !== 3'd0 || tc !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: fQ=%0d tc=%b zero=%b, expected fQ=0 tc=0 zero=1", fQ, tc, zero);
    end
  endtask

  task automatic test_div_by_1();
    load_val = 3'd0; load = 1'b1; en = 1'b0;
    step();
    load = 1'b0; auto_reload = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (fQ !== 3'd0 || tc !== 1'b1 || zero !== 1'b1) begin
        errors++;
        $display("FAIL div1[%0d]: fQ=%0d tc=%b zero=%b, expected fQ=0 tc=1 zero=1", i, fQ, tc, zero);
      end
    end
    en = 1'b0;
    step();
    tests++;
    if (fQ !== 3'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL div1_stop: fQ=%0d tc=%b, expected fQ=0 tc=0", fQ, tc);
    end
  endtask

  initial begin
    tests = 0;
    errors = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 3'd0; auto_reload = 1'b0;
    #2;
    test_reset();
    test_wrap();
    test_divider();
    test_simultaneous();
    test_enable_gating();
    test_div_by_1();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/sync_down_cntr.md
# sync_down_cntr

Synchronous, loadable binary down counter with terminal-count pulse and optional auto-reload. It counts in the opposite direction to the team's ripple up counter. All bits share one clock, so there is no ripple skew. With auto-reload enabled it acts as a programmable divide-by-N pulse generator for the divider chain.

## Interface
Parameters:
- WIDTH, 3, counter and load-value width; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- en  input  1  count enable; one decrement per rising edge while high.
- load  input  1  synchronous load of load_val into count and reload register.
- load_val  input  WIDTH  value captured on load.
- auto_reload  input  1  underflow mode: 1 = reload from reload register, 0 = wrap to all-ones.
- fQ  output  WIDTH  registered count value.
- zero  output  1  combinational, fQ == 0.
- tc  output  1  registered terminal-count pulse, one cycle wide per underflow event.

## Operation
- State is held in three registers: count (drives fQ), reload_reg (WIDTH), and tc_q (drives tc).
- Priority at each rising edge is reset > load > en > hold.
- **reset:**
  - count <= 0, reload_reg <= 0, tc_q <= 0.
  - Applies mid-count and overrides a simultaneous load or en.
- **load:**
  - count <= load_val and reload_reg <= load_val.
  - tc_q <= 0, even if en is also high; no decrement occurs that cycle.
- **en with count != 0:** count <= count - 1, tc_q <= 0.
- **en with count == 0 (underflow event):**
  - tc_q <= 1.
  - If auto_reload = 1: count <= reload_reg.
  - If auto_reload = 0: count <= all-ones (2^WIDTH - 1).
- **Idle (en = 0, no load):** count holds, tc_q <= 0.
- auto_reload is sampled only at the underflow edge. Changing it mid-count has no other effect.
- reload_reg = 0 with auto_reload = 1 is legal and gives divide-by-1: count stays 0 and tc stays high while en is high.
- Divide ratio in auto-reload mode is reload_reg + 1 enabled cycles per tc pulse.
- Arithmetic is modulo 2^WIDTH, unsigned; no saturation.

## Timing
- Reset values: fQ = 0, zero = 1, tc = 0.
- Load latency: 1 cycle. fQ equals load_val in the cycle after the load edge.
- Decrement latency: 1 cycle per enabled edge.
- tc is asserted in the cycle following the underflow edge, aligned with fQ showing the reloaded or wrapped value.
- Back-to-back underflows, e.g. reload_reg = 0 with en held high, keep tc high continuously; every cycle is a distinct event.
- zero is combinational from the count register, so it is valid in the same cycle as fQ. It has no input-to-output combinational path.
- No path from any input to any output is combinational.

## Structure
- Shared package cntr_pkg holds:
  - CNTR_DEFAULT_WIDTH = 3.
  - An underflow-mode enum: MODE_WRAP = 0, MODE_RELOAD = 1. auto_reload is compared against this enum.
- No sub-module. Next-state logic is one priority mux plus a WIDTH-bit decrementer, all inline.
- The T_FlipFlop cell is not used; it would reintroduce ripple clocking.

## Test plan
WIDTH = 3 throughout.
- **Reset:** drive reset for 2 cycles with en = 1 and load = 1 -> fQ = 0, zero = 1, tc = 0 throughout. Releasing reset with en = 1 and auto_reload = 0 -> first edge gives fQ = 7 and tc = 1 for one cycle.
- **Free-running wrap:** auto_reload = 0, en = 1 for 16 cycles from 0 -> fQ sequence 7,6,5,...,0,7,... and tc high exactly in the cycles where fQ = 7 (two pulses).
- **Divider:** load_val = 4, load for 1 cycle, then auto_reload = 1 and en = 1 -> fQ sequence 4,3,2,1,0,4,3,... and tc pulses once every 5 cycles, coincident with fQ = 4 after the reload.
- **Simultaneous events:**
  - load = 1 with en = 1 while fQ = 0 and load_val = 2 -> next fQ = 2, tc = 0.
  - reset = 1 with load = 1 -> fQ = 0 and reload_reg = 0; confirm that a later underflow with auto_reload = 1 yields fQ = 0.
- **Enable gating and mid-operation reset:**
  - From fQ = 5, toggle en 1,0,0,1 -> fQ = 4,4,4,3.
  - Assert reset at fQ = 3 -> fQ = 0 and tc = 0 on the next cycle.
- **Divide-by-1:** load_val = 0, auto_reload = 1, en = 1 for 4 cycles -> fQ = 0 and tc = 1 on all 4 cycles after the first edge; dropping en -> tc = 0 on the next cycle.
